// File: rtl/gcd_operand_feeder_if.sv
// Bundle of the operand, core and result handshakes for gcd_operand_feeder.
// master = feeder side, slave = surrounding system (source, GCD core, sink).
`timescale 1ns/1ps
interface gcd_operand_feeder_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        core_start;
  logic [15:0] core_data;
  logic        core_rst;
  logic        core_done;
  logic [15:0] core_result;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        res_err;

  modport master (
    input  in_valid, in_a, in_b, core_done, core_result, res_ready,
    output in_ready, core_start, core_data, core_rst, res_valid, res_data, res_err
  );

  modport slave (
    output in_valid, in_a, in_b, core_done, core_result, res_ready,
    input  in_ready, core_start, core_data, core_rst, res_valid, res_data, res_err
  );
endinterface

// File: rtl/gcd_operand_feeder.sv
// Operand FIFO + sequencer feeding a subtract-loop GCD core; zero operands bypass the core.
// Optional RUN timeout/abort is enabled by defining GCD_FEEDER_TIMEOUT_EN.
`timescale 1ns/1ps
module gcd_operand_feeder #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  gcd_operand_feeder_if.master bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_LOAD_A = 3'd2;
  localparam logic [2:0] S_LOAD_B = 3'd3;
  localparam logic [2:0] S_RUN    = 3'd4;
  localparam logic [2:0] S_RESULT = 3'd5;
  localparam logic [2:0] S_CLEAR  = 3'd6;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (TIMEOUT < 2)) begin : g_param_check
    $error("gcd_operand_feeder: DEPTH must be a power of two >= 2 and TIMEOUT >= 2");
  end

  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          in_ready_q;
  logic          push, pop;

  logic [2:0]    state_q, state_d;
  logic [15:0]   op_a_q, op_b_q;
  logic          op_zero;
  logic          core_used_q;

  logic          core_start_q, core_rst_q, res_valid_q, res_err_q;
  logic [15:0]   core_data_q, res_data_q;

  // in_ready is registered, so a full FIFO can never see push and pop together.
  assign push    = bus.in_valid && in_ready_q;
  assign pop     = (state_q == S_IDLE) && (count_q != '0);
  assign count_d = count_q + CW'(push) - CW'(pop);
  assign op_zero = (op_a_q == 16'd0) || (op_b_q == 16'd0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {bus.in_a, bus.in_b};
    end
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      {op_a_q, op_b_q} <= mem_q[rd_ptr_q];
    end
  end

`ifdef GCD_FEEDER_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] run_cnt_q;
  logic          timeout_hit;

  assign timeout_hit = (run_cnt_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt_q <= '0;
    end else if (state_q != S_RUN) begin
      run_cnt_q <= '0;
    end else begin
      run_cnt_q <= run_cnt_q + 1'b1;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (count_q != '0) state_d = S_DECODE;
      S_DECODE: state_d = op_zero ? S_RESULT : S_LOAD_A;
      S_LOAD_A: state_d = S_LOAD_B;
      S_LOAD_B: state_d = S_RUN;
      S_RUN: begin
        if (bus.core_done) begin
          state_d = S_RESULT;
        end
`ifdef GCD_FEEDER_TIMEOUT_EN
        else if (timeout_hit) begin
          state_d = S_RESULT;
        end
`endif
      end
      S_RESULT: if (bus.res_ready) state_d = core_used_q ? S_CLEAR : S_IDLE;
      S_CLEAR:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      in_ready_q   <= 1'b0;
      core_used_q  <= 1'b0;
      core_start_q <= 1'b0;
      core_data_q  <= 16'd0;
      core_rst_q   <= 1'b1;
      res_valid_q  <= 1'b0;
      res_data_q   <= 16'd0;
      res_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      in_ready_q   <= (count_d != CW'(DEPTH));
      core_start_q <= (state_d == S_LOAD_A);
      core_rst_q   <= (state_d == S_CLEAR);
      res_valid_q  <= (state_d == S_RESULT);
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;

      if (state_d == S_LOAD_A) core_data_q <= op_a_q;
      if (state_d == S_LOAD_B) core_data_q <= op_b_q;

      if (state_q == S_DECODE) begin
        core_used_q <= !op_zero;
        if (op_zero) begin
          res_data_q <= op_a_q | op_b_q;
          res_err_q  <= 1'b0;
        end
      end

      if ((state_q == S_RUN) && (state_d == S_RESULT)) begin
        if (bus.core_done) begin
          res_data_q <= bus.core_result;
          res_err_q  <= 1'b0;
        end else begin
          res_data_q <= 16'd0;
          res_err_q  <= 1'b1;
        end
      end
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.core_start = core_start_q;
  assign bus.core_data  = core_data_q;
  assign bus.core_rst   = core_rst_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
`ifdef GCD_FEEDER_TIMEOUT_EN
  assign bus.res_err    = res_err_q;
`else
  assign bus.res_err    = 1'b0;
`endif

endmodule

// File: tb/tb_gcd_operand_feeder.sv
// Directed bench for gcd_operand_feeder with a behavioural subtract-loop GCD core.
`timescale 1ns/1ps
module tb_gcd_operand_feeder;
  localparam int DEPTH = 4;
`ifdef GCD_FEEDER_TIMEOUT_EN
  localparam int TIMEOUT = 16;
`else
  localparam int TIMEOUT = 1024;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gcd_operand_feeder_if bus();

  gcd_operand_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural core: latch A on start, B next cycle, subtract until equal.
  logic [15:0] ca, cb;
  logic [1:0]  cst = 2'd0;
  logic        core_hold = 1'b0;

  always @(posedge clk) begin
    if (bus.core_rst) begin
      cst <= 2'd0;
    end else begin
      case (cst)
        2'd0: if (bus.core_start) begin ca <= bus.core_data; cst <= 2'd1; end
        2'd1: begin cb <= bus.core_data; cst <= 2'd2; end
        2'd2: if (!core_hold) begin
          if (ca == cb)     cst <= 2'd3;
          else if (ca > cb) ca <= ca - cb;
          else              cb <= cb - ca;
        end
        default: ;
      endcase
    end
  end
  assign bus.core_done   = (cst == 2'd3);
  assign bus.core_result = ca;

  // Pulse monitor
  int          start_cnt = 0;
  int          rst_cnt = 0;
  logic [15:0] start_data = 16'd0;
  logic [15:0] b_data = 16'd0;
  logic        prev_start = 1'b0;

  always @(negedge clk) begin
    if (bus.core_start) begin
      start_cnt  <= start_cnt + 1;
      start_data <= bus.core_data;
    end
    if (prev_start) b_data <= bus.core_data;
    prev_start <= bus.core_start;
    if (bus.core_rst) rst_cnt <= rst_cnt + 1;
  end

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] b, output logic acc);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_valid = 1'b1;
    acc          = bus.in_ready;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_res(input int limit, output int lat, output logic ok);
    lat = 0;
    while (!bus.res_valid && lat < limit) begin
      @(negedge clk);
      lat++;
    end
    ok = bus.res_valid;
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, s0, r0, acc_cnt, n;
    logic        acc, ok, last_rdy, nonzero;
    logic [15:0] fa[5], fb[5], fexp[5];

    vecs[0] = '{16'd48,  16'd18, 16'd6};
    vecs[1] = '{16'd0,   16'd35, 16'd35};
    vecs[2] = '{16'd0,   16'd0,  16'd0};
    vecs[3] = '{16'd12,  16'd8,  16'd4};
    vecs[4] = '{16'd9,   16'd6,  16'd3};
    vecs[5] = '{16'd21,  16'd14, 16'd7};
    vecs[6] = '{16'd35,  16'd0,  16'd35};
    vecs[7] = '{16'd100, 16'd75, 16'd25};
    vecs[8] = '{16'd17,  16'd5,  16'd1};
    vecs[9] = '{16'd7,   16'd7,  16'd7};
    fa   = '{16'd9, 16'd100, 16'd0, 16'd17, 16'd1};
    fb   = '{16'd6, 16'd75,  16'd5, 16'd5,  16'd1};
    fexp = '{16'd3, 16'd25,  16'd5, 16'd1,  16'd0};

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = 16'd0;
    bus.in_b      = 16'd0;
    bus.res_ready = 1'b0;

    // Reset values
    @(negedge clk);
    check("reset_in_ready", {31'd0, bus.in_ready}, 0);
    check("reset_core_rst", {31'd0, bus.core_rst}, 1);
    check("reset_outputs", {bus.core_start, bus.core_data, bus.res_valid, bus.res_data, bus.res_err},
          {1'b0, 16'd0, 1'b0, 16'd0, 1'b0});
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_in_ready", {31'd0, bus.in_ready}, 1);
    check("post_reset_core_rst", {31'd0, bus.core_rst}, 0);

    // Table-driven single transactions, sink always ready
    bus.res_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s0 = start_cnt;
      r0 = rst_cnt;
      nonzero = (vecs[i].a != 16'd0) && (vecs[i].b != 16'd0);
      push(vecs[i].a, vecs[i].b, acc);
      check("vec_in_ready", {31'd0, acc}, 1);
      wait_res(3000, lat, ok);
      check("vec_res_seen", {31'd0, ok}, 1);
      check("vec_res_data", {16'd0, bus.res_data}, {16'd0, vecs[i].exp});
      check("vec_res_err", {31'd0, bus.res_err}, 0);
      if (!nonzero) check("vec_bypass_latency", lat, 2);
      @(negedge clk);
      check("vec_res_drop", {31'd0, bus.res_valid}, 0);
      repeat (3) @(negedge clk);
      check("vec_start_cycles", start_cnt - s0, nonzero ? 1 : 0);
      if (nonzero) begin
        check("vec_load_a_data", {16'd0, start_data}, {16'd0, vecs[i].a});
        check("vec_load_b_data", {16'd0, b_data}, {16'd0, vecs[i].b});
      end
      check("vec_core_rst_pulses", rst_cnt - r0, nonzero ? 1 : 0);
      $display("vec %0d: a=%0d b=%0d res=%0d lat=%0d", i, vecs[i].a, vecs[i].b, bus.res_data, lat);
    end

    // FIFO fill while the sink stalls: one pair parked in RESULT, DEPTH more fit
    bus.res_ready = 1'b0;
    push(16'd12, 16'd8, acc);
    wait_res(200, lat, ok);
    check("fill_first_parked", {31'd0, ok}, 1);
    acc_cnt  = 0;
    last_rdy = 1'b1;
    for (int i = 0; i <= DEPTH; i++) begin
      bus.in_a     = fa[i];
      bus.in_b     = fb[i];
      bus.in_valid = 1'b1;
      last_rdy     = bus.in_ready;
      if (bus.in_ready) acc_cnt++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("fill_accepted", acc_cnt, DEPTH);
    check("fill_in_ready_full", {31'd0, last_rdy}, 0);
    check("fill_head_held", {bus.res_valid, bus.res_data}, {1'b1, 16'd4});
    $display("fill: accepted %0d pairs, in_ready at extra push=%0d", acc_cnt, last_rdy);
    bus.res_ready = 1'b1;
    check("fill_r0", {16'd0, bus.res_data}, 32'd4);
    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) begin
      wait_res(200, lat, ok);
      check("fill_res_seen", {31'd0, ok}, 1);
      check("fill_res_order", {16'd0, bus.res_data}, {16'd0, fexp[i]});
      $display("fill result %0d: %0d", i, bus.res_data);
      @(negedge clk);
    end
    wait_res(40, lat, ok);
    check("fill_no_extra_result", {31'd0, ok}, 0);

    // Sink stall in RESULT: output held, queued pair kept, core_rst only after acceptance
    bus.res_ready = 1'b0;
    push(16'd48, 16'd18, acc);
    wait_res(200, lat, ok);
    check("stall_res_seen", {31'd0, ok}, 1);
    r0 = rst_cnt;
    push(16'd0, 16'd7, acc);
    check("stall_queue_push", {31'd0, acc}, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_hold", {bus.res_valid, bus.res_data, bus.res_err}, {1'b1, 16'd6, 1'b0});
    end
    check("stall_no_core_rst", rst_cnt - r0, 0);
    bus.res_ready = 1'b1;
    @(negedge clk);
    check("stall_accept_drop", {bus.res_valid, bus.core_rst}, {1'b0, 1'b1});
    wait_res(200, lat, ok);
    check("stall_next_result", {ok, bus.res_data}, {1'b1, 16'd7});
    $display("stall: held result 6, then queued result %0d", bus.res_data);
    @(negedge clk);
    repeat (3) @(negedge clk);

    // Reset three cycles into RUN
    push(16'd1000, 16'd1, acc);
    push(16'd5, 16'd0, acc);
    n = 0;
    while (!bus.core_start && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("midrun_start_seen", {31'd0, bus.core_start}, 1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrun_core_rst", {31'd0, bus.core_rst}, 1);
    check("midrun_outputs", {bus.in_ready, bus.core_start, bus.core_data, bus.res_valid, bus.res_data, bus.res_err},
          {1'b0, 1'b0, 16'd0, 1'b0, 16'd0, 1'b0});
    rst = 1'b0;
    @(negedge clk);
    check("midrun_in_ready", {31'd0, bus.in_ready}, 1);
    wait_res(30, lat, ok);
    check("midrun_fifo_empty", {31'd0, ok}, 0);
    r0 = rst_cnt;
    push(16'd21, 16'd14, acc);
    wait_res(200, lat, ok);
    check("midrun_after_reset", {ok, bus.res_data}, {1'b1, 16'd7});
    @(negedge clk);
    repeat (3) @(negedge clk);
    check("midrun_clear_pulse", rst_cnt - r0, 1);
    $display("midrun reset: recovered, (21,14) -> %0d", bus.res_data);

`ifdef GCD_FEEDER_TIMEOUT_EN
    // Abort: done never arrives; RUN entered two cycles after LOAD_A
    core_hold = 1'b1;
    push(16'd30, 16'd12, acc);
    n = 0;
    while (!bus.core_start && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("to_start_seen", {31'd0, bus.core_start}, 1);
    n = 0;
    while (!bus.res_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("to_latency", n, 2 + TIMEOUT);
    check("to_result", {bus.res_valid, bus.res_data, bus.res_err}, {1'b1, 16'd0, 1'b1});
    @(negedge clk);
    check("to_core_rst", {31'd0, bus.core_rst}, 1);
    core_hold = 1'b0;
    $display("timeout: res_valid %0d cycles after LOAD_A", n);
    repeat (3) @(negedge clk);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
